// File: rtl/cpu_pkg.sv
// Shared definitions for the 4004-style core: opcode nibbles, phase numbers
// within the 8-phase instruction cycle, and the instruction sequencer state.
package cpu_pkg;

  localparam logic [3:0] OP_JCN     = 4'h1;
  localparam logic [3:0] OP_FIM_SRC = 4'h2;
  localparam logic [3:0] OP_FIN_JIN = 4'h3;
  localparam logic [3:0] OP_JUN     = 4'h4;
  localparam logic [3:0] OP_JMS     = 4'h5;
  localparam logic [3:0] OP_ISZ     = 4'h7;
  localparam logic [3:0] OP_BBL     = 4'hC;

  localparam logic [2:0] CYC_M1 = 3'd3;
  localparam logic [2:0] CYC_M2 = 3'd4;
  localparam logic [2:0] CYC_X2 = 3'd6;
  localparam logic [2:0] CYC_X3 = 3'd7;

  typedef enum logic [0:0] {FETCH1 = 1'b0, FETCH2 = 1'b1} seq_state_e;

  // FIM and SRC share OPR 0x2; only FIM (opa[0]=0) carries a data word.
  function automatic logic is_two_word(input logic [3:0] opr, input logic [3:0] opa);
    return (opr == OP_JCN) || (opr == OP_JUN) || (opr == OP_JMS) ||
           (opr == OP_ISZ) || ((opr == OP_FIM_SRC) && !opa[0]);
  endfunction

endpackage

// File: rtl/return_stack.sv
// Circular subroutine return-address stack.
// Ports: clk/rst (async high), push/pop strobes (never together), din = address
// to push, dout = entry a pop returns (combinational, entry[wp-1]),
// depth = valid entries, overflow/underflow = sticky misuse flags.
module return_stack #(
  parameter int STACK_DEPTH = 3,
  parameter int ADDR_W      = 12,
  parameter int PW          = $clog2(STACK_DEPTH),
  parameter int DW          = $clog2(STACK_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] din,
  output logic [ADDR_W-1:0] dout,
  output logic [DW-1:0]     depth,
  output logic              overflow,
  output logic              underflow
);

  logic [ADDR_W-1:0] mem_q [STACK_DEPTH];
  logic [PW-1:0]     wp_q, wp_inc, wp_dec;
  logic [DW-1:0]     depth_q;
  logic              ovf_q, unf_q;

  assign wp_inc = (wp_q == PW'(STACK_DEPTH - 1)) ? '0 : wp_q + 1'b1;
  assign wp_dec = (wp_q == '0) ? PW'(STACK_DEPTH - 1) : wp_q - 1'b1;

  // Popping an empty stack still hands back whatever sits below wp.
  assign dout      = mem_q[wp_dec];
  assign depth     = depth_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STACK_DEPTH; i++) mem_q[i] <= '0;
      wp_q    <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else if (push) begin
      mem_q[wp_q] <= din;
      wp_q        <= wp_inc;
      if (depth_q == DW'(STACK_DEPTH)) ovf_q <= 1'b1;  // oldest entry lost
      else                             depth_q <= depth_q + 1'b1;
    end else if (pop) begin
      wp_q <= wp_dec;
      if (depth_q == '0) unf_q <= 1'b1;
      else               depth_q <= depth_q - 1'b1;
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// Instruction-level controller: latches OPR/OPA (and the second word of
// two-word instructions) from the ROM nibble stream, decides jumps at the
// X2 edge so pcLoad/pcNew/instrDone/fimStrobe are high during X3, and owns
// the JMS/BBL return stack.
// Inputs : clk, rst (async high), cycle (phase 0-7), romNibble, pcAddr,
//          ccTrue / iszZero / pairData (valid in X2).
// Outputs: opr, opa, word2, secondWord, instrDone, pcLoad, pcNew, fimStrobe,
//          stackDepth, stackOverflow, stackUnderflow.
module instr_sequencer
  import cpu_pkg::*;
#(
  parameter int STACK_DEPTH = 3,
  parameter int ADDR_W      = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        cycle,
  input  logic [3:0]        romNibble,
  input  logic [ADDR_W-1:0] pcAddr,
  input  logic              ccTrue,
  input  logic              iszZero,
  input  logic [7:0]        pairData,
  output logic [3:0]        opr,
  output logic [3:0]        opa,
  output logic [7:0]        word2,
  output logic              secondWord,
  output logic              instrDone,
  output logic              pcLoad,
  output logic [ADDR_W-1:0] pcNew,
  output logic              fimStrobe,
  output logic [1:0]        stackDepth,
  output logic              stackOverflow,
  output logic              stackUnderflow
);

  seq_state_e        state_q;
  logic [3:0]        opr_q, opa_q;
  logic [7:0]        word2_q;
  logic              load_q, done_q, fim_q;
  logic [ADDR_W-1:0] new_q;

  logic              load_d, done_d, fim_d, push, pop;
  logic [ADDR_W-1:0] new_d, addr_inc, stk_dout;
  logic [ADDR_W-1:0] short_tgt;

  // Short jumps stay in the page of the *next* word, so xFF crosses a page.
  assign addr_inc  = pcAddr + 1'b1;
  assign short_tgt = {addr_inc[ADDR_W-1:8], word2_q};

  always_comb begin
    load_d = 1'b0;
    new_d  = '0;
    done_d = 1'b0;
    fim_d  = 1'b0;
    push   = 1'b0;
    pop    = 1'b0;
    if (cycle == CYC_X2) begin
      if (state_q == FETCH1) begin
        if (!is_two_word(opr_q, opa_q)) begin
          done_d = 1'b1;
          if (opr_q == OP_FIN_JIN && opa_q[0]) begin
            load_d = 1'b1;
            new_d  = {addr_inc[ADDR_W-1:8], pairData};
          end else if (opr_q == OP_BBL) begin
            pop    = 1'b1;
            load_d = 1'b1;
            new_d  = stk_dout;
          end
        end
      end else begin
        done_d = 1'b1;
        case (opr_q)
          OP_JUN: begin
            load_d = 1'b1;
            new_d  = {opa_q, word2_q};
          end
          OP_JMS: begin
            push   = 1'b1;
            load_d = 1'b1;
            new_d  = {opa_q, word2_q};
          end
          OP_JCN: if (ccTrue) begin
            load_d = 1'b1;
            new_d  = short_tgt;
          end
          OP_ISZ: if (!iszZero) begin
            load_d = 1'b1;
            new_d  = short_tgt;
          end
          default: fim_d = 1'b1;  // only FIM reaches FETCH2 otherwise
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH1;
      opr_q   <= '0;
      opa_q   <= '0;
      word2_q <= '0;
      load_q  <= 1'b0;
      new_q   <= '0;
      done_q  <= 1'b0;
      fim_q   <= 1'b0;
    end else begin
      // Pulses are re-evaluated every edge, so they last exactly one clk.
      load_q <= load_d;
      new_q  <= new_d;
      done_q <= done_d;
      fim_q  <= fim_d;
      if (cycle == CYC_M1) begin
        if (state_q == FETCH1) opr_q <= romNibble;
        else                   word2_q[7:4] <= romNibble;
      end
      if (cycle == CYC_M2) begin
        if (state_q == FETCH1) opa_q <= romNibble;
        else                   word2_q[3:0] <= romNibble;
      end
      if (cycle == CYC_X3)
        state_q <= (state_q == FETCH1 && is_two_word(opr_q, opa_q)) ? FETCH2 : FETCH1;
    end
  end

  return_stack #(.STACK_DEPTH(STACK_DEPTH), .ADDR_W(ADDR_W)) u_stack (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .din      (addr_inc),
    .dout     (stk_dout),
    .depth    (stackDepth),
    .overflow (stackOverflow),
    .underflow(stackUnderflow)
  );

  assign opr        = opr_q;
  assign opa        = opa_q;
  assign word2      = word2_q;
  assign secondWord = (state_q == FETCH2);
  assign instrDone  = done_q;
  assign pcLoad     = load_q;
  assign pcNew      = new_q;
  assign fimStrobe  = fim_q;

endmodule

// File: tb/tb_instr_sequencer.sv
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  cycle = '0;
  logic [3:0]  romNibble = '0;
  logic [11:0] pcAddr = '0;
  logic        ccTrue = 1'b0;
  logic        iszZero = 1'b0;
  logic [7:0]  pairData = '0;
  logic [3:0]  opr, opa;
  logic [7:0]  word2;
  logic        secondWord, instrDone, pcLoad, fimStrobe;
  logic [11:0] pcNew;
  logic [1:0]  stackDepth;
  logic        stackOverflow, stackUnderflow;

  int errors = 0;
  int checks = 0;

  // Observations captured by run_word.
  logic        cap_load, cap_done, cap_fim, cap_sw;
  logic [11:0] cap_new;
  logic [7:0]  cap_w2;
  int          n_load, n_done, n_fim;

  always #5 clk = ~clk;

  instr_sequencer dut (
    .clk(clk), .rst(rst), .cycle(cycle), .romNibble(romNibble), .pcAddr(pcAddr),
    .ccTrue(ccTrue), .iszZero(iszZero), .pairData(pairData),
    .opr(opr), .opa(opa), .word2(word2), .secondWord(secondWord),
    .instrDone(instrDone), .pcLoad(pcLoad), .pcNew(pcNew), .fimStrobe(fimStrobe),
    .stackDepth(stackDepth), .stackOverflow(stackOverflow), .stackUnderflow(stackUnderflow)
  );

  // One full 8-phase word. Off-phase nibbles are 0xF to expose mis-latching.
  task automatic run_word(input logic [11:0] addr, input logic [3:0] hi, input logic [3:0] lo,
                          input logic cc, input logic isz, input logic [7:0] pair);
    n_load = 0; n_done = 0; n_fim = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      cycle     = 3'(c);
      romNibble = (c == 3) ? hi : (c == 4) ? lo : 4'hF;
      pcAddr    = addr;
      ccTrue    = cc;
      iszZero   = isz;
      pairData  = pair;
      @(posedge clk);
      #1;
      n_load += int'(pcLoad);
      n_done += int'(instrDone);
      n_fim  += int'(fimStrobe);
      if (c == 3) cap_sw = secondWord;
      if (c == 6) begin
        cap_load = pcLoad; cap_new = pcNew; cap_done = instrDone;
        cap_fim = fimStrobe; cap_w2 = word2;
      end
    end
  endtask

  task automatic test_reset;
    #12;
    checks++;
    if ({opr, opa, word2, secondWord, instrDone, pcLoad, pcNew, fimStrobe,
         stackDepth, stackOverflow, stackUnderflow} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: opr=%h opa=%h w2=%h sw=%b done=%b load=%b new=%h depth=%0d",
               opr, opa, word2, secondWord, instrDone, pcLoad, pcNew, stackDepth);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_jun;
    run_word(12'h000, 4'h4, 4'h3, 0, 0, 8'h00);
    checks++;
    if (cap_sw !== 1'b0 || n_load != 0 || n_done != 0) begin
      errors++;
      $display("FAIL jun_word1: sw=%b loads=%0d dones=%0d want 0/0/0", cap_sw, n_load, n_done);
    end
    run_word(12'h001, 4'h2, 4'h1, 0, 0, 8'h00);
    checks++;
    if (cap_sw !== 1'b1 || cap_load !== 1'b1 || cap_new !== 12'h321) begin
      errors++;
      $display("FAIL jun_target: sw=%b load=%b new=%h want 1/1/321", cap_sw, cap_load, cap_new);
    end
    checks++;
    if (n_load != 1 || n_done != 1 || secondWord !== 1'b0) begin
      errors++;
      $display("FAIL jun_pulses: loads=%0d dones=%0d sw_after=%b want 1/1/0", n_load, n_done, secondWord);
    end
  endtask

  task automatic test_jms_bbl;
    run_word(12'h010, 4'h5, 4'h1, 0, 0, 8'h00);
    run_word(12'h011, 4'h2, 4'h3, 0, 0, 8'h00);
    checks++;
    if (cap_load !== 1'b1 || cap_new !== 12'h123 || stackDepth !== 2'd1) begin
      errors++;
      $display("FAIL jms_call: load=%b new=%h depth=%0d want 1/123/1", cap_load, cap_new, stackDepth);
    end
    run_word(12'h123, 4'hC, 4'h0, 0, 0, 8'h00);
    checks++;
    if (cap_load !== 1'b1 || cap_new !== 12'h012 || cap_done !== 1'b1 || stackDepth !== 2'd0) begin
      errors++;
      $display("FAIL bbl_return: load=%b new=%h done=%b depth=%0d want 1/012/1/0",
               cap_load, cap_new, cap_done, stackDepth);
    end
  endtask

  task automatic test_cond_jumps;
    run_word(12'h0FE, 4'h1, 4'h4, 0, 0, 8'h00);
    run_word(12'h0FF, 4'h4, 4'h0, 1, 0, 8'h00);
    checks++;
    if (cap_load !== 1'b1 || cap_new !== 12'h140) begin
      errors++;
      $display("FAIL jcn_taken_pagecross: load=%b new=%h want 1/140", cap_load, cap_new);
    end
    run_word(12'h0FE, 4'h1, 4'h4, 0, 0, 8'h00);
    run_word(12'h0FF, 4'h4, 4'h0, 0, 0, 8'h00);
    checks++;
    if (n_load != 0 || n_done != 1) begin
      errors++;
      $display("FAIL jcn_not_taken: loads=%0d dones=%0d want 0/1", n_load, n_done);
    end
    run_word(12'h200, 4'h7, 4'h0, 0, 0, 8'h00);
    run_word(12'h201, 4'h8, 4'h5, 0, 0, 8'h00);
    checks++;
    if (cap_load !== 1'b1 || cap_new !== 12'h285) begin
      errors++;
      $display("FAIL isz_loop: load=%b new=%h want 1/285", cap_load, cap_new);
    end
    run_word(12'h200, 4'h7, 4'h0, 0, 0, 8'h00);
    run_word(12'h201, 4'h8, 4'h5, 0, 1, 8'h00);
    checks++;
    if (n_load != 0 || n_done != 1) begin
      errors++;
      $display("FAIL isz_exit: loads=%0d dones=%0d want 0/1", n_load, n_done);
    end
  endtask

  task automatic test_nested;
    logic [11:0] rets [4];
    rets = '{12'h402, 12'h302, 12'h202, 12'h402};
    for (int k = 0; k < 4; k++) begin
      logic [11:0] a;
      a = 12'h100 * (k + 1);
      run_word(a, 4'h5, 4'(k + 2), 0, 0, 8'h00);
      run_word(a + 12'h001, 4'h0, 4'h0, 0, 0, 8'h00);
      if (k == 2) begin
        checks++;
        if (stackDepth !== 2'd3 || stackOverflow !== 1'b0) begin
          errors++;
          $display("FAIL nest_full: depth=%0d ovf=%b want 3/0", stackDepth, stackOverflow);
        end
      end
    end
    checks++;
    if (stackDepth !== 2'd3 || stackOverflow !== 1'b1 || cap_new !== 12'h500) begin
      errors++;
      $display("FAIL nest_overflow: depth=%0d ovf=%b new=%h want 3/1/500", stackDepth, stackOverflow, cap_new);
    end
    for (int k = 0; k < 4; k++) begin
      run_word(12'h555, 4'hC, 4'h0, 0, 0, 8'h00);
      checks++;
      if (cap_new !== rets[k] || cap_load !== 1'b1) begin
        errors++;
        $display("FAIL bbl_pop%0d: new=%h load=%b want %h/1", k, cap_new, cap_load, rets[k]);
      end
      if (k == 2) begin
        checks++;
        if (stackDepth !== 2'd0 || stackUnderflow !== 1'b0) begin
          errors++;
          $display("FAIL nest_empty: depth=%0d unf=%b want 0/0", stackDepth, stackUnderflow);
        end
      end
    end
    checks++;
    if (stackDepth !== 2'd0 || stackUnderflow !== 1'b1 || stackOverflow !== 1'b1) begin
      errors++;
      $display("FAIL nest_underflow: depth=%0d unf=%b ovf=%b want 0/1/1", stackDepth, stackUnderflow, stackOverflow);
    end
  endtask

  task automatic test_fim_jin;
    run_word(12'h020, 4'h2, 4'h0, 0, 0, 8'h00);
    run_word(12'h021, 4'hA, 4'h5, 0, 0, 8'h00);
    checks++;
    if (cap_fim !== 1'b1 || cap_w2 !== 8'hA5 || n_load != 0 || n_fim != 1 || n_done != 1) begin
      errors++;
      $display("FAIL fim: fim=%b w2=%h loads=%0d fims=%0d dones=%0d want 1/a5/0/1/1",
               cap_fim, cap_w2, n_load, n_fim, n_done);
    end
    run_word(12'h2FF, 4'h3, 4'h1, 0, 0, 8'h7C);
    checks++;
    if (cap_load !== 1'b1 || cap_new !== 12'h37C || cap_done !== 1'b1 || opr !== 4'h3 || opa !== 4'h1) begin
      errors++;
      $display("FAIL jin: load=%b new=%h done=%b opr=%h opa=%h want 1/37c/1/3/1",
               cap_load, cap_new, cap_done, opr, opa);
    end
  endtask

  task automatic test_rst_mid;
    int stray;
    run_word(12'h000, 4'h4, 4'h3, 0, 0, 8'h00);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      cycle = 3'(c); romNibble = (c == 3) ? 4'h2 : 4'hF; pcAddr = 12'h001;
      @(posedge clk);
    end
    @(negedge clk);
    cycle = 3'd4; romNibble = 4'h1;
    rst = 1'b1;
    #1;
    checks++;
    if ({opr, opa, word2, secondWord, instrDone, pcLoad, pcNew, fimStrobe,
         stackDepth, stackOverflow, stackUnderflow} !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs: opr=%h w2=%h sw=%b load=%b ovf=%b unf=%b want all 0",
               opr, word2, secondWord, pcLoad, stackOverflow, stackUnderflow);
    end
    stray = 0;
    for (int c = 5; c < 8; c++) begin
      @(negedge clk);
      cycle = 3'(c);
      @(posedge clk); #1;
      stray += int'(pcLoad);
    end
    @(negedge clk);
    rst = 1'b0;
    // A one-word NOP: if the sequencer still thought it was in word 2 this
    // would complete the JUN and load the PC.
    run_word(12'h002, 4'h0, 4'h0, 0, 0, 8'h00);
    checks++;
    if (stray != 0 || cap_sw !== 1'b0 || n_load != 0 || n_done != 1 || opr !== 4'h0) begin
      errors++;
      $display("FAIL rst_mid_recover: stray=%0d sw=%b loads=%0d dones=%0d opr=%h want 0/0/0/1/0",
               stray, cap_sw, n_load, n_done, opr);
    end
  endtask

  initial begin
    test_reset();
    test_jun();
    test_jms_bbl();
    test_cond_jumps();
    test_nested();
    test_fim_jin();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
